// File: rtl/aesl_dl_pkg.sv
// ============================================================================
// Module   : aesl_dl_pkg
// Brief    : Shared types and helpers for the dataflow deadlock cycle monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package aesl_dl_pkg;

  typedef enum logic [1:0] {
    DL_IDLE   = 2'd0,
    DL_WALK   = 2'd1,
    DL_REPORT = 2'd2
  } dl_state_e;

  localparam int DL_TS_W = 32;

  // Index width that never collapses to zero bits.
  function automatic int dl_clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/aesl_dl_stall_ctr.sv
// ============================================================================
// Module   : aesl_dl_stall_ctr
// Brief    : Per-process saturating stall counter over a stable wait target.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aesl_dl_stall_ctr
  import aesl_dl_pkg::*;
#(
  parameter int NUM_PROC     = 2,
  parameter int STALL_THRESH = 16,
  parameter int IDX_W        = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             blk,
  input  logic [IDX_W-1:0] wait_on,
  input  logic             clr,
  output logic             stalled
);

  localparam int               CNT_W   = dl_clog2(STALL_THRESH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_THRESH);

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [IDX_W-1:0] prev_d, prev_q;
  logic             prev_vld_d, prev_vld_q;
  logic             in_range;
  logic             same_target;

  // Right after reset there is no previous target, so nothing can differ.
  always_comb begin
    in_range    = (int'(wait_on) < NUM_PROC);
    same_target = !prev_vld_q || (wait_on == prev_q);
    cnt_d       = cnt_q;
    prev_d      = wait_on;
    prev_vld_d  = 1'b1;
    if (clr || !blk || !in_range || !same_target) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
    end
  end

  assign stalled = (cnt_q == CNT_MAX);

endmodule

`default_nettype wire

// File: rtl/aesl_dl_cycle_monitor.sv
// ============================================================================
// Module   : aesl_dl_cycle_monitor
// Brief    : Wait-for-graph walker that latches a confirmed deadlock cycle.
//            Optional macro AESL_DL_TIMESTAMP_EN adds a cycle timestamp output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aesl_dl_cycle_monitor
  import aesl_dl_pkg::*;
#(
  parameter  int NUM_PROC     = 2,
  parameter  int STALL_THRESH = 16,
  localparam int IDX_W        = dl_clog2(NUM_PROC)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_PROC-1:0]       proc_blk,
  input  logic [NUM_PROC*IDX_W-1:0] proc_wait_on,
  input  logic                      dl_clear,
  output logic                      busy,
  output logic                      dl_detect,
  output logic [IDX_W-1:0]          dl_origin,
  output logic [NUM_PROC-1:0]       dl_cycle_mask,
`ifdef AESL_DL_TIMESTAMP_EN
  output logic [DL_TS_W-1:0]        dl_timestamp,
`endif
  output logic [IDX_W:0]            dl_len
);

  localparam int PAD_N = 1 << IDX_W;

  logic [NUM_PROC-1:0]    stalled;
  logic [PAD_N-1:0]       stalled_pad;
  logic [PAD_N-1:0]       visited_pad;
  logic [PAD_N*IDX_W-1:0] wait_pad;
  logic [IDX_W-1:0]       wait_arr [PAD_N];
  logic                   clr_ctr;

  for (genvar gi = 0; gi < NUM_PROC; gi++) begin : g_stall
    aesl_dl_stall_ctr #(
      .NUM_PROC     (NUM_PROC),
      .STALL_THRESH (STALL_THRESH),
      .IDX_W        (IDX_W)
    ) u_ctr (
      .clock   (clock),
      .reset   (reset),
      .blk     (proc_blk[gi]),
      .wait_on (proc_wait_on[gi*IDX_W +: IDX_W]),
      .clr     (clr_ctr),
      .stalled (stalled[gi])
    );
  end

  dl_state_e             state_d, state_q;
  logic [IDX_W-1:0]      origin_d, origin_q;
  logic [IDX_W-1:0]      cur_d, cur_q;
  logic [NUM_PROC-1:0]   visited_d, visited_q;
  logic [IDX_W:0]        len_d, len_q;
  logic [IDX_W-1:0]      rr_ptr_d, rr_ptr_q;
  logic [IDX_W-1:0]      dl_origin_d, dl_origin_q;
  logic [NUM_PROC-1:0]   dl_mask_d, dl_mask_q;
  logic [IDX_W:0]        dl_len_d, dl_len_q;
  logic                  sel_found;
  logic [IDX_W-1:0]      sel_idx;
  logic [IDX_W-1:0]      nxt;

  // Power-of-two padding keeps every lookup indexed by an in-range value.
  always_comb begin
    stalled_pad = PAD_N'(stalled);
    visited_pad = PAD_N'(visited_q);
    wait_pad    = (PAD_N*IDX_W)'(proc_wait_on);
    for (int i = 0; i < PAD_N; i++) begin
      wait_arr[i] = wait_pad[i*IDX_W +: IDX_W];
    end
    nxt = wait_arr[cur_q];
  end

  // First stalled process at or after rr_ptr, circularly.
  always_comb begin
    int               j;
    logic [IDX_W-1:0] j_idx;
    sel_found = 1'b0;
    sel_idx   = '0;
    j         = 0;
    j_idx     = '0;
    for (int k = 0; k < NUM_PROC; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= NUM_PROC) begin
        j = j - NUM_PROC;
      end
      j_idx = IDX_W'(j);
      if (!sel_found && stalled_pad[j_idx]) begin
        sel_found = 1'b1;
        sel_idx   = j_idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    origin_d    = origin_q;
    cur_d       = cur_q;
    visited_d   = visited_q;
    len_d       = len_q;
    rr_ptr_d    = rr_ptr_q;
    dl_origin_d = dl_origin_q;
    dl_mask_d   = dl_mask_q;
    dl_len_d    = dl_len_q;
    clr_ctr     = 1'b0;
    busy        = 1'b0;
    dl_detect   = 1'b0;
    unique case (state_q)
      DL_IDLE: begin
        if (sel_found) begin
          origin_d  = sel_idx;
          cur_d     = sel_idx;
          visited_d = NUM_PROC'(1) << sel_idx;
          len_d     = (IDX_W+1)'(1);
          state_d   = DL_WALK;
        end
      end
      DL_WALK: begin
        busy = 1'b1;
        if (!stalled_pad[nxt]) begin
          rr_ptr_d = (origin_q == IDX_W'(NUM_PROC - 1)) ? '0 : origin_q + IDX_W'(1);
          state_d  = DL_IDLE;
        end else if (nxt == origin_q) begin
          dl_origin_d = origin_q;
          dl_mask_d   = visited_q;
          dl_len_d    = len_q;
          state_d     = DL_REPORT;
        end else if (visited_pad[nxt]) begin
          // Origin sits on a tail; restart the search on the loop itself.
          rr_ptr_d = nxt;
          state_d  = DL_IDLE;
        end else begin
          visited_d = visited_q | (NUM_PROC'(1) << nxt);
          cur_d     = nxt;
          len_d     = len_q + (IDX_W+1)'(1);
        end
      end
      DL_REPORT: begin
        dl_detect = 1'b1;
        if (dl_clear) begin
          clr_ctr     = 1'b1;
          dl_origin_d = '0;
          dl_mask_d   = '0;
          dl_len_d    = '0;
          state_d     = DL_IDLE;
        end
      end
      default: state_d = DL_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= DL_IDLE;
      origin_q    <= '0;
      cur_q       <= '0;
      visited_q   <= '0;
      len_q       <= '0;
      rr_ptr_q    <= '0;
      dl_origin_q <= '0;
      dl_mask_q   <= '0;
      dl_len_q    <= '0;
    end else begin
      state_q     <= state_d;
      origin_q    <= origin_d;
      cur_q       <= cur_d;
      visited_q   <= visited_d;
      len_q       <= len_d;
      rr_ptr_q    <= rr_ptr_d;
      dl_origin_q <= dl_origin_d;
      dl_mask_q   <= dl_mask_d;
      dl_len_q    <= dl_len_d;
    end
  end

  assign dl_origin     = dl_origin_q;
  assign dl_cycle_mask = dl_mask_q;
  assign dl_len        = dl_len_q;

`ifdef AESL_DL_TIMESTAMP_EN
  logic [DL_TS_W-1:0] ts_d, ts_q;
  logic [DL_TS_W-1:0] dl_ts_d, dl_ts_q;

  always_comb begin
    ts_d    = ts_q + DL_TS_W'(1);
    dl_ts_d = dl_ts_q;
    if (state_q == DL_WALK && state_d == DL_REPORT) begin
      dl_ts_d = ts_q;
    end else if (state_q == DL_REPORT && state_d == DL_IDLE) begin
      dl_ts_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ts_q    <= '0;
      dl_ts_q <= '0;
    end else begin
      ts_q    <= ts_d;
      dl_ts_q <= dl_ts_d;
    end
  end

  assign dl_timestamp = dl_ts_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_aesl_dl_cycle_monitor.sv
// ============================================================================
// Module   : tb_aesl_dl_cycle_monitor
// Brief    : Directed self-checking bench for the deadlock cycle monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aesl_dl_cycle_monitor;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       rst_a, rst_b;
  logic [1:0] a_blk, a_wait;
  logic       a_clr, a_busy, a_det;
  logic [0:0] a_origin;
  logic [1:0] a_mask, a_len;
  logic [3:0] b_blk;
  logic [7:0] b_wait;
  logic       b_clr, b_busy, b_det;
  logic [1:0] b_origin;
  logic [3:0] b_mask;
  logic [2:0] b_len;
`ifdef AESL_DL_TIMESTAMP_EN
  logic [31:0] a_ts, b_ts;
`endif

  aesl_dl_cycle_monitor #(.NUM_PROC(2), .STALL_THRESH(4)) u_dut_a (
    .clock         (clock),
    .reset         (rst_a),
    .proc_blk      (a_blk),
    .proc_wait_on  (a_wait),
    .dl_clear      (a_clr),
    .busy          (a_busy),
    .dl_detect     (a_det),
    .dl_origin     (a_origin),
    .dl_cycle_mask (a_mask),
`ifdef AESL_DL_TIMESTAMP_EN
    .dl_timestamp  (a_ts),
`endif
    .dl_len        (a_len)
  );

  aesl_dl_cycle_monitor #(.NUM_PROC(4), .STALL_THRESH(4)) u_dut_b (
    .clock         (clock),
    .reset         (rst_b),
    .proc_blk      (b_blk),
    .proc_wait_on  (b_wait),
    .dl_clear      (b_clr),
    .busy          (b_busy),
    .dl_detect     (b_det),
    .dl_origin     (b_origin),
    .dl_cycle_mask (b_mask),
`ifdef AESL_DL_TIMESTAMP_EN
    .dl_timestamp  (b_ts),
`endif
    .dl_len        (b_len)
  );

  int checks = 0;
  int errors = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_det;
    rst_a = 1'b1; rst_b = 1'b1;
    a_blk = '0; a_wait = '0; a_clr = 1'b0;
    b_blk = '0; b_wait = '0; b_clr = 1'b0;
    tick(2);
    chk("reset_a_busy", a_busy, 0);
    chk("reset_a_det", a_det, 0);
    chk("reset_a_origin", a_origin, 0);
    chk("reset_a_mask", a_mask, 0);
    chk("reset_a_len", a_len, 0);
    chk("reset_b_det", b_det, 0);

    // Two-process ring: 0 -> 1 -> 0, both blocked from the first cycle.
    a_blk = 2'b11; a_wait = 2'b01;
    tick(1);
    rst_a = 1'b0;
    tick(4); chk("t1_idle_e4", a_busy, 0);
    tick(1); chk("t1_walk_e5", a_busy, 1);
    tick(1); chk("t1_nodet_e6", a_det, 0);
    tick(1);
    chk("t1_det", a_det, 1);
    chk("t1_origin", a_origin, 0);
    chk("t1_mask", a_mask, 2'b11);
    chk("t1_len", a_len, 2);
    chk("t1_busy_off", a_busy, 0);
`ifdef AESL_DL_TIMESTAMP_EN
    chk("t1_ts", a_ts, 6);
`endif

    // Report holds while inputs change, then clear and re-detect.
    a_blk = 2'b00;
    tick(2);
    chk("t6_hold_det", a_det, 1);
    chk("t6_hold_mask", a_mask, 2'b11);
    a_clr = 1'b1; tick(1); a_clr = 1'b0;
    chk("t6_clr_det", a_det, 0);
    chk("t6_clr_mask", a_mask, 0);
    chk("t6_clr_len", a_len, 0);
    a_blk = 2'b11;
    tick(4); chk("t6_rearm_idle", a_busy, 0);
    tick(1); chk("t6_rearm_walk", a_busy, 1);
    tick(2);
    chk("t6_redet", a_det, 1);
    chk("t6_redet_mask", a_mask, 2'b11);
`ifdef AESL_DL_TIMESTAMP_EN
    chk("t6_ts", a_ts, 16);
`endif

    // Reset asserted mid-walk aborts everything.
    a_clr = 1'b1; tick(1); a_clr = 1'b0;
    tick(5); chk("t6_walk_before_rst", a_busy, 1);
    rst_a = 1'b1;
    tick(1);
    chk("t6_rst_busy", a_busy, 0);
    chk("t6_rst_det", a_det, 0);
    chk("t6_rst_len", a_len, 0);
    a_blk = 2'b00; rst_a = 1'b0;

    // Self-loop on process 2.
    b_blk = 4'b0100; b_wait = 8'h20;
    tick(1); rst_b = 1'b0;
    tick(4); chk("t2_idle", b_busy, 0);
    tick(1); chk("t2_walk", b_busy, 1);
    tick(1);
    chk("t2_det", b_det, 1);
    chk("t2_origin", b_origin, 2);
    chk("t2_mask", b_mask, 4'b0100);
    chk("t2_len", b_len, 1);
    b_clr = 1'b1; tick(1); b_clr = 1'b0;
    chk("t2_clr_det", b_det, 0);

    // Open chain 0 -> 1 -> 2 with process 2 running: walks abort, rr_ptr moves.
    rst_b = 1'b1; b_blk = 4'b0011; b_wait = 8'h09;
    tick(1); rst_b = 1'b0;
    tick(5); chk("t3_walk0", b_busy, 1);
    tick(2); chk("t3_abort0", b_busy, 0);
    tick(1); chk("t3_walk1", b_busy, 1);
    tick(1); chk("t3_abort1_short", b_busy, 0);
    tick(1); chk("t3_walk_again", b_busy, 1);
    seen_det = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      seen_det = seen_det | b_det;
    end
    chk("t3_never_detect", seen_det, 0);

    // Tail into a loop: 0 -> 1 -> 2 -> 1.
    rst_b = 1'b1; b_blk = 4'b0111; b_wait = 8'h19;
    tick(1); rst_b = 1'b0;
    tick(5); chk("t4_walk0", b_busy, 1);
    tick(3);
    chk("t4_tail_abort", b_busy, 0);
    chk("t4_tail_nodet", b_det, 0);
    tick(1); chk("t4_walk1", b_busy, 1);
    tick(1); chk("t4_nodet_yet", b_det, 0);
    tick(1);
    chk("t4_det", b_det, 1);
    chk("t4_origin", b_origin, 1);
    chk("t4_mask", b_mask, 4'b0110);
    chk("t4_len", b_len, 2);

    // Release one cycle short of the threshold.
    rst_b = 1'b1; b_blk = 4'b0010; b_wait = 8'h04;
    tick(1); rst_b = 1'b0;
    tick(3); b_blk = 4'b0000;
    tick(1); chk("t5_release_idle", b_busy, 0);
    b_blk = 4'b0010;
    tick(1); chk("t5_restart_e5", b_busy, 0);
    tick(3); chk("t5_restart_e8", b_busy, 0);
    tick(1); chk("t5_walk", b_busy, 1);
    tick(1);
    chk("t5_det", b_det, 1);
    chk("t5_origin", b_origin, 1);
    chk("t5_mask", b_mask, 4'b0010);
    chk("t5_len", b_len, 1);

    // Target switch mid-stall restarts the count.
    b_clr = 1'b1; tick(1); b_clr = 1'b0;
    chk("t5_clr_det", b_det, 0);
    tick(3); b_wait = 8'h0C;
    tick(1); chk("t5_switch_idle", b_busy, 0);
    tick(1); chk("t5_switch_e5", b_busy, 0);
    tick(3); chk("t5_switch_e8", b_busy, 0);
    tick(1); chk("t5_switch_walk", b_busy, 1);
    tick(1);
    chk("t5_switch_abort", b_busy, 0);
    chk("t5_switch_nodet", b_det, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
